// File: rtl/sram_controller_if.sv
// MEM-stage data-memory request bus: the pipeline is the master, the SRAM controller the slave.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores as lo/hi 16-bit accesses on an external SRAM.
// Optional SRAM_FAST_READ_EN: one-entry last-write buffer that answers matching reads without SRAM cycles.
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  sram_controller_if.slave mem,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;
  typedef struct packed {
    logic        wr;
    logic [16:0] widx;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_in, req_q, req_cur;
  logic [3:0]  cnt, cnt_nxt;
  logic        acc, hit, last, phase_lo, phase_hi, drive, wr_cyc;
  logic [17:0] addr_hold;
  logic [15:0] dq_hold, lo_buf;
  logic [31:0] rdata_q, hit_data;

  always_comb begin
    req_in.wr    = mem.wr_en;
    req_in.widx  = 17'((mem.address - 32'(ADDR_BASE)) >> 2);
    req_in.wdata = mem.write_data;
  end

  // The acceptance cycle doubles as the first cycle of the lo phase, so the SRAM
  // pins follow the live request there and the latched copy afterwards.
  assign acc      = rst & (mem.wr_en | mem.rd_en);
  assign req_cur  = (state == IDLE) ? req_in : req_q;
  assign last     = (cnt == 4'(WAIT_CYCLES - 1));
  assign phase_lo = (state == IDLE && acc && !hit) || state == WR_LO || state == RD_LO;
  assign phase_hi = (state == WR_HI) || (state == RD_HI);
  assign drive    = phase_lo | phase_hi;
  assign wr_cyc   = drive & req_cur.wr;

  assign sram_addr   = drive  ? {req_cur.widx, phase_hi} : addr_hold;
  assign sram_dq_out = wr_cyc ? (phase_hi ? req_cur.wdata[31:16] : req_cur.wdata[15:0]) : dq_hold;
  assign sram_we_n   = ~wr_cyc;
  assign sram_dq_oe  = wr_cyc;

  assign mem.ready     = (state == IDLE && !acc) || (state == DONE);
  assign mem.read_data = rdata_q;

`ifdef SRAM_FAST_READ_EN
  logic        fr_valid;
  logic [16:0] fr_idx;
  logic [31:0] fr_data;

  assign hit      = acc & ~mem.wr_en & fr_valid & (fr_idx == req_in.widx) & (state == IDLE);
  assign hit_data = fr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fr_valid <= 1'b0;
      fr_idx   <= '0;
      fr_data  <= '0;
    end else if (state == WR_HI && last) begin
      fr_valid <= 1'b1;
      fr_idx   <= req_q.widx;
      fr_data  <= req_q.wdata;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = drive ? (last ? 4'd0 : cnt + 4'd1) : 4'd0;
    case (state)
      IDLE:
        if (acc) begin
          if (hit)            state_nxt = DONE;
          else if (mem.wr_en) state_nxt = last ? WR_HI : WR_LO;
          else                state_nxt = last ? RD_HI : RD_LO;
        end
      WR_LO:   if (last) state_nxt = WR_HI;
      WR_HI:   if (last) state_nxt = DONE;
      RD_LO:   if (last) state_nxt = RD_HI;
      RD_HI:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      addr_hold <= '0;
      dq_hold   <= '0;
      lo_buf    <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr_hold <= sram_addr;
      dq_hold   <= sram_dq_out;
      if (state == IDLE && acc) req_q <= req_in;
      // lo half is staged so read_data only moves when the whole word is in
      if (phase_lo && last && !req_cur.wr) lo_buf <= sram_dq_in;
      if (phase_hi && last && !req_cur.wr) rdata_q <= {sram_dq_in, lo_buf};
      if (hit) rdata_q <= hit_data;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded bench for sram_controller with a behavioural halfword SRAM and word-level reference model.
module tb_sram_controller;

`ifdef SRAM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  sram_controller_if bus();

  sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem(bus),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    int          stall;
    int          we_cyc;
    int          oe_cyc;
    logic [17:0] a_first;
    logic [17:0] a_last;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] smem[int];
  logic [31:0] ref_word[int];
  logic [31:0] last_rd;
  bit          fr_valid;
  int          fr_idx;
  int          total, bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] srd(input int a);
    return smem.exists(a) ? smem[a] : 16'h0;
  endfunction

  // behavioural SRAM: write on the clock while strobed, read data presented mid-cycle
  initial forever begin
    @(posedge clk);
    if (sram_we_n === 1'b0) smem[int'(sram_addr)] = sram_dq_out;
  end
  initial begin
    sram_dq_in = 16'h0;
    forever begin
      @(negedge clk);
      sram_dq_in = srd(int'(sram_addr));
    end
  end

  // monitor: measure each stall window, check it against the next scoreboard entry
  initial begin
    int m_stall, m_we, m_oe;
    logic [17:0] m_first, m_last;
    exp_t e;
    m_stall = 0; m_we = 0; m_oe = 0; m_first = '0; m_last = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_stall = 0; m_we = 0; m_oe = 0;
      end else if (!bus.ready) begin
        m_stall++;
        if (!sram_we_n) begin
          if (m_we == 0) m_first = sram_addr;
          m_last = sram_addr;
          m_we++;
        end
        if (sram_dq_oe) m_oe++;
      end else if (m_stall > 0) begin
        if (sbq.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("stall_cycles", m_stall, e.stall);
          chk("we_cycles", m_we, e.we_cyc);
          chk("oe_cycles", m_oe, e.oe_cyc);
          chk("read_data", bus.read_data, e.rdata);
          if (e.is_wr) begin
            chk("wr_first_addr", m_first, e.a_first);
            chk("wr_last_addr", m_last, e.a_last);
          end
        end
        m_stall = 0; m_we = 0; m_oe = 0;
      end
    end
  end

  task automatic xact(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    bit   got;
    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    idx = int'(((addr - 32'd1024) >> 2) & 32'h1FFFF);
    e.is_wr = wr; e.a_first = 18'(idx * 2); e.a_last = 18'(idx * 2 + 1);
    if (wr) begin
      e.stall = 8; e.we_cyc = 8; e.oe_cyc = 8; e.rdata = last_rd;
      ref_word[idx] = data; fr_valid = 1'b1; fr_idx = idx;
    end else begin
      e.rdata = ref_word.exists(idx) ? ref_word[idx] : 32'h0;
      e.stall = (FAST && fr_valid && fr_idx == idx) ? 1 : 8;
      e.we_cyc = 0; e.oe_cyc = 0;
      last_rd = e.rdata;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    // request inputs wiggle mid-transaction and must be ignored
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = $urandom; bus.write_data = $urandom;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (bus.ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [17:0] a0;
    int idx, sel;
    logic [31:0] addr;
    total = 0; bad = 0; last_rd = '0; fr_valid = 1'b0; fr_idx = 0; a0 = '0;
    bus.wr_en = 0; bus.rd_en = 0; bus.address = '0; bus.write_data = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    @(negedge clk); rst = 1'b1;

    xact(1, 0, 32'd1024, 32'hDEADBEEF);
    chk("t1_half0", srd(0), 16'hBEEF);
    chk("t1_half1", srd(1), 16'hDEAD);
    xact(0, 1, 32'd1024, 32'h0);
    xact(1, 0, 32'd1032, 32'h0000CAFE);
    chk("t3_half4", srd(4), 16'hCAFE);
    chk("t3_half5", srd(5), 16'h0000);
    xact(1, 1, 32'd1024, 32'h11112222);

    // reset abort in the 2nd cycle of the hi write phase
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.address = 32'd1104; bus.write_data = 32'hA5A55A5A;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("t5_mid_we_n", sram_we_n, 0);
    chk("t5_mid_addr", sram_addr, 18'd41);
    rst = 1'b0;
    #1;
    chk("t5_we_n", sram_we_n, 1);
    chk("t5_ready", bus.ready, 1);
    chk("t5_read_data", bus.read_data, 0);
    chk("t5_oe", sram_dq_oe, 0);
    last_rd = '0; fr_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b1;

    xact(1, 0, 32'd1040, 32'h12345678);
    a0 = sram_addr;
    xact(0, 1, 32'd1040, 32'h0);
    if (FAST) chk("t6_addr_unchanged", sram_addr, a0);
    xact(0, 1, 32'd1044, 32'h0);

    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 15);
      addr = 32'd1024 + 32'(idx) * 4;
      sel = $urandom_range(0, 7);
      if (sel == 0) addr = addr + 32'h80000;
      if (sel == 1) addr = addr - 32'h80000;
      sel = $urandom_range(0, 9);
      if (sel < 4)       xact(1, 0, addr, $urandom);
      else if (sel < 9)  xact(0, 1, addr, $urandom);
      else               xact(1, 1, addr, $urandom);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    foreach (ref_word[k]) begin
      chk("mem_lo", srd(k * 2), ref_word[k][15:0]);
      chk("mem_hi", srd(k * 2 + 1), ref_word[k][31:16]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
